// File: rtl/scoreboard_hazard_unit_pkg.sv
// Shared opcode map, register-field mask encodings and the per-slot
// decode function for the scoreboard hazard unit.
package scoreboard_hazard_unit_pkg;

  localparam int NUM_REGISTERS_LOG2 = 5;
  localparam int OP_CODE_BITS       = 6;

  localparam logic [OP_CODE_BITS-1:0] OP_NOP = 6'b000000;
  localparam logic [OP_CODE_BITS-1:0] OP_JR  = 6'b001000;
  localparam logic [OP_CODE_BITS-1:0] OP_LW  = 6'b100011;
  localparam logic [OP_CODE_BITS-1:0] OP_SW  = 6'b101011;
  localparam logic [OP_CODE_BITS-1:0] OP_LA  = 6'b110000;
  localparam logic [OP_CODE_BITS-1:0] OP_SA  = 6'b110001;

  // One bit per instruction register field; used for both sources and destinations.
  localparam logic [2:0] FIELD_NONE = 3'b000;
  localparam logic [2:0] FIELD_RS   = 3'b001;
  localparam logic [2:0] FIELD_RT   = 3'b010;
  localparam logic [2:0] FIELD_RD   = 3'b100;

  typedef struct packed {
    logic [2:0] src_mask;
    logic [2:0] dst_mask;
    logic       is_load;
  } slot_decode_t;

  function automatic slot_decode_t decode_op(input logic [OP_CODE_BITS-1:0] op);
    slot_decode_t d;
    d = '{src_mask: FIELD_NONE, dst_mask: FIELD_NONE, is_load: 1'b0};
    if (op == OP_JR) begin
      d.src_mask = FIELD_RS;
    end else if (op == OP_LW) begin
      d.src_mask = FIELD_RS;
      d.dst_mask = FIELD_RT;
      d.is_load  = 1'b1;
    end else if (op == OP_SW) begin
      d.src_mask = FIELD_RS | FIELD_RT;
    end else if (op == OP_LA) begin
      d.dst_mask = FIELD_RT;
    end else if (op == OP_SA) begin
      d.src_mask = FIELD_RT;
    end else if (op[OP_CODE_BITS-1 -: 2] == 2'b00 && op != OP_NOP) begin
      d.src_mask = FIELD_RS | FIELD_RT;
      d.dst_mask = FIELD_RD;
    end else if (op[OP_CODE_BITS-1 -: 2] == 2'b01) begin
      d.src_mask = FIELD_RS;
      d.dst_mask = FIELD_RT;
    end
    return d;
  endfunction

endpackage

// File: rtl/scoreboard_hazard_unit_slot_decode.sv
// Per-slot decode: opcode to source/destination field masks and the
// architectural destination register.
module hazard_slot_decode
  import scoreboard_hazard_unit_pkg::*;
#(
  parameter int REG_BITS = NUM_REGISTERS_LOG2
) (
  input  logic [OP_CODE_BITS-1:0] opcode,
  input  logic [REG_BITS-1:0]     rt,
  input  logic [REG_BITS-1:0]     rd,
  output logic [2:0]              src_mask,
  output logic [2:0]              dst_mask,
  output logic [REG_BITS-1:0]     dst_reg,
  output logic                    is_load
);

  slot_decode_t dec;

  assign dec      = decode_op(opcode);
  assign src_mask = dec.src_mask;
  assign dst_mask = dec.dst_mask;
  assign is_load  = dec.is_load;
  assign dst_reg  = dec.dst_mask[2] ? rd : rt;

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// Multi-issue hazard unit: load-use scoreboard plus intra-bundle RAW/WAW
// checks, in-order issue selection and a saturating stall counter.
module scoreboard_hazard_unit
  import scoreboard_hazard_unit_pkg::*;
#(
  parameter int ISSUE_WIDTH  = 2,
  parameter int LOAD_LATENCY = 1,
  parameter int REG_BITS     = NUM_REGISTERS_LOG2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic [ISSUE_WIDTH-1:0]           slot_valid,
  input  logic [$clog2(ISSUE_WIDTH)-1:0]   oldest,
  input  logic [ISSUE_WIDTH*OP_CODE_BITS-1:0] opcode,
  input  logic [ISSUE_WIDTH*REG_BITS-1:0]  rs,
  input  logic [ISSUE_WIDTH*REG_BITS-1:0]  rt,
  input  logic [ISSUE_WIDTH*REG_BITS-1:0]  rd,
  input  logic                             downstream_ready,
  output logic [ISSUE_WIDTH-1:0]           issue_mask,
  output logic                             stall,
  output logic [ISSUE_WIDTH-1:0]           clear_mask,
  output logic [2**REG_BITS-1:0]           busy,
  output logic [15:0]                      stall_count
);

  localparam int NUM_REGS = 2**REG_BITS;
  localparam int CW       = $clog2(LOAD_LATENCY + 1);

  logic [2:0]          src_mask [ISSUE_WIDTH];
  logic [2:0]          dst_mask [ISSUE_WIDTH];
  logic [REG_BITS-1:0] dst_reg  [ISSUE_WIDTH];
  logic [REG_BITS-1:0] rs_f     [ISSUE_WIDTH];
  logic [REG_BITS-1:0] rt_f     [ISSUE_WIDTH];
  logic [REG_BITS-1:0] rd_f     [ISSUE_WIDTH];
  logic [ISSUE_WIDTH-1:0] is_load;
  logic [ISSUE_WIDTH-1:0] blocked;
  logic [NUM_REGS-1:0]    load_set;
  logic [CW-1:0]          cnt [NUM_REGS];
  int                     age [ISSUE_WIDTH];

  for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_slot
    assign rs_f[g] = rs[g*REG_BITS +: REG_BITS];
    assign rt_f[g] = rt[g*REG_BITS +: REG_BITS];
    assign rd_f[g] = rd[g*REG_BITS +: REG_BITS];

    hazard_slot_decode #(.REG_BITS(REG_BITS)) u_decode (
      .opcode   (opcode[g*OP_CODE_BITS +: OP_CODE_BITS]),
      .rt       (rt_f[g]),
      .rd       (rd_f[g]),
      .src_mask (src_mask[g]),
      .dst_mask (dst_mask[g]),
      .dst_reg  (dst_reg[g]),
      .is_load  (is_load[g])
    );
  end

  // Program-order position of each slot: 0 is the oldest.
  always_comb begin
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      age[i] = (i + ISSUE_WIDTH - int'(oldest)) % ISSUE_WIDTH;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    blocked = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if ((src_mask[i][0] && busy[rs_f[i]]) ||
          (src_mask[i][1] && busy[rt_f[i]]) ||
          (src_mask[i][2] && busy[rd_f[i]])) begin
        blocked[i] = 1'b1;
      end
      for (int j = 0; j < ISSUE_WIDTH; j++) begin
        if (slot_valid[j] && age[j] < age[i] && |dst_mask[j] &&
            ((src_mask[i][0] && rs_f[i] == dst_reg[j]) ||
             (src_mask[i][1] && rt_f[i] == dst_reg[j]) ||
             (src_mask[i][2] && rd_f[i] == dst_reg[j]) ||
             (|dst_mask[i] && dst_reg[i] == dst_reg[j]))) begin
          blocked[i] = 1'b1;
        end
      end
    end
  end

  // Walk slots oldest-first; the first valid slot that cannot go stops the rest.
  always_comb begin : issue_select
    logic in_order_ok;
    issue_mask  = '0;
    in_order_ok = downstream_ready && !flush && !reset;
    for (int p = 0; p < ISSUE_WIDTH; p++) begin
      for (int s = 0; s < ISSUE_WIDTH; s++) begin
        if (age[s] == p && slot_valid[s]) begin
          if (in_order_ok && !blocked[s]) issue_mask[s] = 1'b1;
          else                            in_order_ok   = 1'b0;
        end
      end
    end
  end

  assign stall      = !flush && !reset && |(slot_valid & ~issue_mask);
  assign clear_mask = stall ? issue_mask : '0;

  always_comb begin
    load_set = '0;
    for (int s = 0; s < ISSUE_WIDTH; s++) begin
      if (issue_mask[s] && is_load[s]) load_set[dst_reg[s]] = 1'b1;
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) busy[r] = (cnt[r] != '0);
  end

  // NOTE: the counter array is reset explicitly because busy must read clear right after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      stall_count <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every counter updating from pre-edge values.
      for (int r = 0; r < NUM_REGS; r++) begin
        if (load_set[r])         cnt[r] <= CW'(LOAD_LATENCY);
        else if (cnt[r] != '0)   cnt[r] <= cnt[r] - 1'b1;
      end
      if (stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed and randomized bench for scoreboard_hazard_unit against a
// set-based reference model of the issue and scoreboard rules.
module tb_scoreboard_hazard_unit;
  import scoreboard_hazard_unit_pkg::*;

  localparam int W   = 2;
  localparam int LAT = 1;
  localparam int RB  = 5;
  localparam int NR  = 32;

  localparam logic [5:0] T_ADD  = 6'b000001;
  localparam logic [5:0] T_ADDI = 6'b010000;

  logic            clk = 1'b0;
  logic            reset, flush, ready;
  logic [W-1:0]    slot_valid;
  logic [0:0]      oldest;
  logic [W*6-1:0]  opcode;
  logic [W*RB-1:0] rs, rt, rd;
  logic [W-1:0]    issue_mask, clear_mask;
  logic            stall;
  logic [NR-1:0]   busy;
  logic [15:0]     stall_count;

  always #5 clk = ~clk;

  scoreboard_hazard_unit #(.ISSUE_WIDTH(W), .LOAD_LATENCY(LAT), .REG_BITS(RB)) dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .slot_valid       (slot_valid),
    .oldest           (oldest),
    .opcode           (opcode),
    .rs               (rs),
    .rt               (rt),
    .rd               (rd),
    .downstream_ready (ready),
    .issue_mask       (issue_mask),
    .stall            (stall),
    .clear_mask       (clear_mask),
    .busy             (busy),
    .stall_count      (stall_count)
  );

  int checks = 0;
  int failures = 0;

  int           mcnt [NR];
  int           msc;
  logic [W-1:0] exp_issue, exp_clear;
  logic         exp_stall;
  logic [W-1:0] obs_issue, obs_clear;
  logic         obs_stall;
  logic [31:0]  obs_busy;
  logic [15:0]  obs_sc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode expressed as register sets over opcode ranges.
  function automatic void decode_ref(input logic [5:0] op, input logic [4:0] a, b, c,
                                     output logic [31:0] srcs, output int dst, output bit ld);
    srcs = '0; dst = -1; ld = 1'b0;
    if (op == OP_JR) srcs[a] = 1'b1;
    else if (op == OP_LW) begin srcs[a] = 1'b1; dst = int'(b); ld = 1'b1; end
    else if (op == OP_SW) begin srcs[a] = 1'b1; srcs[b] = 1'b1; end
    else if (op == OP_LA) dst = int'(b);
    else if (op == OP_SA) srcs[b] = 1'b1;
    else if (op != OP_NOP && op < 6'd16) begin srcs[a] = 1'b1; srcs[b] = 1'b1; dst = int'(c); end
    else if (op >= 6'd16 && op < 6'd32) begin srcs[a] = 1'b1; dst = int'(b); end
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) mcnt[r] = 0;
    msc = 0;
  endtask

  task automatic model_comb();
    logic [31:0] written, bset, srcs;
    int dst, s;
    bit ld, halted;
    bset = '0;
    for (int r = 0; r < NR; r++) if (mcnt[r] > 0) bset[r] = 1'b1;
    written = '0;
    exp_issue = '0;
    halted = flush || !ready;
    for (int p = 0; p < W; p++) begin
      s = (int'(oldest) + p) % W;
      if (slot_valid[s]) begin
        decode_ref(opcode[s*6 +: 6], rs[s*RB +: RB], rt[s*RB +: RB], rd[s*RB +: RB], srcs, dst, ld);
        if (!halted && (srcs & (bset | written)) == 0 && !(dst >= 0 && written[dst]))
          exp_issue[s] = 1'b1;
        else
          halted = 1'b1;
        if (dst >= 0) written[dst] = 1'b1;
      end
    end
    exp_stall = !flush && ((slot_valid & ~exp_issue) != '0);
    exp_clear = exp_stall ? exp_issue : '0;
  endtask

  task automatic model_clock();
    logic [31:0] srcs;
    int dst;
    bit ld;
    for (int r = 0; r < NR; r++) if (mcnt[r] > 0) mcnt[r]--;
    for (int s = 0; s < W; s++) begin
      if (exp_issue[s]) begin
        decode_ref(opcode[s*6 +: 6], rs[s*RB +: RB], rt[s*RB +: RB], rd[s*RB +: RB], srcs, dst, ld);
        if (ld) mcnt[dst] = LAT;
      end
    end
    if (exp_stall && msc < 65535) msc++;
  endtask

  // One clock: sample at negedge, optionally compare against the model, then advance.
  task automatic cycle(input bit chk, input string tag);
    logic [31:0] mbusy;
    @(negedge clk);
    model_comb();
    obs_issue = issue_mask; obs_stall = stall; obs_clear = clear_mask;
    obs_busy = busy; obs_sc = stall_count;
    if (chk) begin
      mbusy = '0;
      for (int r = 0; r < NR; r++) if (mcnt[r] > 0) mbusy[r] = 1'b1;
      check({tag, ".issue"}, 32'(obs_issue), 32'(exp_issue));
      check({tag, ".stall"}, 32'(obs_stall), 32'(exp_stall));
      check({tag, ".clear"}, 32'(obs_clear), 32'(exp_clear));
      check({tag, ".busy"},  obs_busy, mbusy);
      check({tag, ".scnt"},  32'(obs_sc), 32'(msc));
    end
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic set_slot(input int s, input logic [5:0] op, input logic [4:0] a, b, c);
    opcode[s*6 +: 6] = op;
    rs[s*RB +: RB] = a;
    rt[s*RB +: RB] = b;
    rd[s*RB +: RB] = c;
  endtask

  function automatic logic [5:0] rand_op();
    case ($urandom_range(9))
      0: return OP_NOP;
      1: return OP_JR;
      2: return OP_LW;
      3: return OP_SW;
      4: return OP_LA;
      5: return OP_SA;
      6: return 6'($urandom_range(15));
      7: return 6'(16 + $urandom_range(15));
      default: return 6'($urandom_range(63));
    endcase
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; ready = 1'b1; slot_valid = '0; oldest = '0;
    opcode = '0; rs = '0; rt = '0; rd = '0;
    model_reset();

    // Outputs held quiet during reset even with a full bundle present.
    #2;
    set_slot(0, T_ADD, 5'd1, 5'd2, 5'd3);
    set_slot(1, T_ADD, 5'd4, 5'd5, 5'd6);
    slot_valid = 2'b11;
    #1;
    check("rst.issue", 32'(issue_mask), 32'h0);
    check("rst.stall", 32'(stall), 32'h0);
    check("rst.clear", 32'(clear_mask), 32'h0);
    check("rst.busy",  busy, 32'h0);
    check("rst.scnt",  32'(stall_count), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Build stall_count=5 and busy[9]=1, then reset in the middle of a stall.
    slot_valid = 2'b01; ready = 1'b0;
    repeat (5) cycle(1, "prestall");
    ready = 1'b1;
    set_slot(0, OP_LW, 5'd1, 5'd9, 5'd0);
    cycle(1, "lw9");
    set_slot(0, T_ADD, 5'd9, 5'd2, 5'd3);
    @(negedge clk);
    check("midstall.busy9", 32'(busy[9]), 32'h1);
    check("midstall.scnt",  32'(stall_count), 32'd5);
    check("midstall.stall", 32'(stall), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("async_rst.busy",  busy, 32'h0);
    check("async_rst.scnt",  32'(stall_count), 32'h0);
    check("async_rst.issue", 32'(issue_mask), 32'h0);
    check("async_rst.stall", 32'(stall), 32'h0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    cycle(1, "post_rst");
    check("post_rst.issues", 32'(obs_issue), 32'h1);

    // Load-use: LW r5 then dependent ADD.
    set_slot(0, OP_LW, 5'd1, 5'd5, 5'd0); slot_valid = 2'b01;
    cycle(1, "lu.lw");
    check("lu.lw_issue", 32'(obs_issue), 32'h1);
    set_slot(0, T_ADD, 5'd5, 5'd2, 5'd6);
    cycle(1, "lu.hold");
    check("lu.hold_issue", 32'(obs_issue), 32'h0);
    check("lu.hold_stall", 32'(obs_stall), 32'h1);
    cycle(1, "lu.go");
    check("lu.go_issue", 32'(obs_issue), 32'h1);

    // Intra-bundle RAW, oldest=0.
    oldest = 1'b0;
    set_slot(0, T_ADDI, 5'd1, 5'd3, 5'd0);
    set_slot(1, T_ADD,  5'd3, 5'd2, 5'd8);
    slot_valid = 2'b11;
    cycle(1, "raw");
    check("raw.issue", 32'(obs_issue), 32'h1);
    check("raw.clear", 32'(obs_clear), 32'h1);
    slot_valid = 2'b10;
    cycle(1, "raw2");
    check("raw2.issue", 32'(obs_issue), 32'h2);

    // Wrapped order, oldest=1: LA rt=r7 ahead of SW reading r7.
    oldest = 1'b1;
    set_slot(1, OP_LA, 5'd0, 5'd7, 5'd0);
    set_slot(0, OP_SW, 5'd2, 5'd7, 5'd0);
    slot_valid = 2'b11;
    cycle(1, "wrap");
    check("wrap.issue", 32'(obs_issue), 32'h2);
    check("wrap.clear", 32'(obs_clear), 32'h2);
    slot_valid = 2'b01;
    cycle(1, "wrap2");
    check("wrap2.issue", 32'(obs_issue), 32'h1);

    // Flush after LW r4: nothing issues, no stall, load still retires.
    oldest = 1'b0;
    set_slot(0, OP_LW, 5'd1, 5'd4, 5'd0); slot_valid = 2'b01;
    cycle(1, "fl.lw");
    flush = 1'b1;
    set_slot(0, T_ADD, 5'd4, 5'd2, 5'd3);
    set_slot(1, T_ADD, 5'd1, 5'd2, 5'd11);
    slot_valid = 2'b11;
    cycle(1, "fl.a");
    check("fl.a_issue", 32'(obs_issue), 32'h0);
    check("fl.a_stall", 32'(obs_stall), 32'h0);
    check("fl.a_busy4", 32'(obs_busy[4]), 32'h1);
    cycle(1, "fl.b");
    check("fl.b_busy4", 32'(obs_busy[4]), 32'h0);
    flush = 1'b0;

    // Downstream not ready: stall while the scoreboard keeps draining.
    set_slot(0, OP_LW, 5'd1, 5'd10, 5'd0); slot_valid = 2'b01;
    cycle(1, "nr.lw");
    ready = 1'b0;
    set_slot(0, T_ADD, 5'd1, 5'd2, 5'd12);
    cycle(1, "nr.a");
    check("nr.a_stall", 32'(obs_stall), 32'h1);
    check("nr.a_busy10", 32'(obs_busy[10]), 32'h1);
    cycle(1, "nr.b");
    check("nr.b_busy10", 32'(obs_busy[10]), 32'h0);
    ready = 1'b1;

    // Randomized bundles against the reference model.
    for (int n = 0; n < 400; n++) begin
      flush = ($urandom_range(7) == 0);
      ready = ($urandom_range(7) != 0);
      oldest = 1'($urandom_range(1));
      slot_valid = 2'($urandom_range(3));
      for (int s = 0; s < W; s++)
        set_slot(s, rand_op(), 5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)));
      cycle(1, "rand");
    end

    // Saturation of the stall counter.
    flush = 1'b0; ready = 1'b0; oldest = 1'b0; slot_valid = 2'b01;
    set_slot(0, T_ADD, 5'd1, 5'd2, 5'd3);
    repeat (65540) cycle(0, "sat");
    cycle(1, "sat_end");
    check("sat.scnt", 32'(obs_sc), 32'h0000FFFF);
    cycle(1, "sat_hold");
    check("sat_hold.scnt", 32'(obs_sc), 32'h0000FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
